multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Sequencing FSM for the multicycle MIPS core: one shared memory port, one ALU, and PC/IR/A/B/ALUOut/MDR registers.
- Decodes `operation`/`func` from the IR and drives per-cycle datapath selects and write enables.
- Stalls on a memory ready handshake.
- Drop-in controller for the non-pipelined build; uses the same ALU control encoding as the pipeline:
  - 000 and, 001 or, 010 add, 011 sll, 100 srl, 101 sra, 110 sub, 111 slt.

Parameters:
- JAL_LINK_REG, 31, register index that `jal` writes.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  synchronous active-low reset; sampled on the rising edge of `clk`.
- operation  input  6  IR[31:26].
- func  input  6  IR[5:0].
- zero  input  1  ALU result == 0.
- mem_ready  input  1  memory completes the current access this cycle.
- mem_re  output  1  memory read request.
- mem_we  output  1  memory write request.
- iord  output  1  0 = address from PC, 1 = address from ALUOut.
- ir_we  output  1  IR load.
- pc_en  output  1  PC load.
- pc_src  output  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs.
- reg_we  output  1  register file write.
- sel_reg_write_addr  output  2  00 rt, 01 rd, 10 JAL_LINK_REG.
- sel_reg_write_data  output  2  00 ALUOut, 01 MDR, 10 PC.
- sel_alu_src_a  output  2  00 PC, 01 A, 10 shamt.
- sel_alu_src_b  output  2  00 B, 01 constant 4, 10 sign-extended imm, 11 imm<<2.
- alu_control  output  3  ALU operation (encoding above).
- state  output  4  current state, for debug.
- illegal  output  1  sticky illegal-instruction flag.

Behaviour:
- Moore FSM, registered state. Outputs are combinational from state, except:
  - `pc_en`/`ir_we` gated by `mem_ready` in FETCH;
  - `pc_en` gated by `zero` in BRANCH.
- Reset (`rst_n`=0 at an edge): state=FETCH, illegal=0. This aborts any operation in flight, including a pending memory access.
- Default for every output: 0. Undriven selects = 00.
- FETCH:
  - mem_re=1, iord=0; A=PC, B=4, add, pc_src=00.
  - ir_we=pc_en=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - A=PC, B=imm<<2, add (branch target latched into ALUOut).
  - Next state by opcode:
    - lw/sw → MEM_ADDR
    - R-type → EXEC_R, except sll/srl/sra → EXEC_SHIFT and jr (func 001000) → JR
    - addi/andi/ori → EXEC_I
    - beq/bne → BRANCH
    - j → JUMP
    - jal → JAL
    - other → TRAP
  - An unknown R-type func also → TRAP.
- MEM_ADDR: A=A, B=imm, add. Next: MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_re=1, iord=1. Hold until mem_ready, then → MEM_WB.
- MEM_WB: reg_we=1, addr=rt, data=MDR. Then → FETCH.
- MEM_WRITE: mem_we=1, iord=1. Hold until mem_ready, then → FETCH.
- EXEC_R: A=A, B=B; alu_control decoded from func:
  - and 100100, or 100101, add 100000, sub 100010, slt 101010, sllv 000100, srlv 000110, srav 000111.
  - Then → ALU_WB.
- EXEC_SHIFT: A=shamt, B=B; sll/srl/sra map to 011/100/101. Then → ALU_WB.
- ALU_WB: reg_we=1, addr=rd, data=ALUOut. Then → FETCH.
- EXEC_I: A=A, B=imm; add/and/or for addi/andi/ori. Then → I_WB.
- I_WB: reg_we=1, addr=rt, data=ALUOut. Then → FETCH.
- BRANCH:
  - A=A, B=B, sub, pc_src=01.
  - pc_en = zero for beq, !zero for bne.
  - Then → FETCH.
- JUMP: pc_src=10, pc_en=1. Then → FETCH.
- JR: pc_src=11, pc_en=1. Then → FETCH.
- JAL: pc_src=10, pc_en=1, reg_we=1, addr=10, data=PC (the PC value before this edge, i.e. PC+4). Then → FETCH.
- TRAP: illegal=1, all enables 0. Stays in TRAP until reset.
- Latency with mem_ready held at 1:
  - R-type / immediate: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq / bne / j / jr / jal: 3 cycles
  - Each cycle of mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- Memory request signals stay asserted and stable until the cycle `mem_ready`=1. `mem_ready` is ignored in all other states.

Optional Feature:
- Macro: MULTICYCLE_PERF_CNT_EN.
- Defined:
  - Adds outputs `cycle_cnt[31:0]` and `instr_cnt[31:0]`; both clear on reset.
  - `cycle_cnt` increments every cycle except in TRAP.
  - `instr_cnt` increments on each FETCH→DECODE transition.
  - Both wrap modulo 2^32.
- Undefined: the ports and logic are absent; the remaining behaviour is identical.

Decomposition:
- mips_pkg holds:
  - the `state_t` enum (4-bit);
  - opcode and func localparams;
  - `alu_ctrl_t` (3-bit, encoding above);
  - select-encoding localparams for pc_src, reg write address/data, and ALU src a/b.
- Sub-module `mc_perf_counters` holds the counters under the macro.
- Next-state and output logic stay in `multicycle_controller`.

Test Plan:
- add $3,$1,$2 (op 000000, func 100000), mem_ready=1 → FETCH, DECODE, EXEC_R (alu_control=010), ALU_WB (reg_we=1, addr=01, data=00); next FETCH at cycle 4.
- lw, mem_ready=0 for 2 cycles in MEM_READ → mem_re=1, iord=1 held; MEM_WB after 7 cycles total; reg_we=1, data=01.
- beq with zero=1 → pc_en=1, pc_src=01 in BRANCH. bne with zero=1 → pc_en=0. Both return to FETCH.
- jal → single JAL cycle: pc_en=1, pc_src=10, reg_we=1, addr=10, data=10.
- op 111111 → TRAP after DECODE, illegal=1, all enables 0 for 10 cycles. Then rst_n=0 → FETCH, illegal=0.
- rst_n=0 asserted in MEM_WRITE with mem_ready=0 → next state FETCH and mem_we=0. With MULTICYCLE_PERF_CNT_EN defined, instr_cnt=0 after reset.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcode/func
// values, ALU control codes and datapath select encodings.
package mips_pkg;

  typedef enum logic [3:0] {
    StFetch     = 4'd0,
    StDecode    = 4'd1,
    StMemAddr   = 4'd2,
    StMemRead   = 4'd3,
    StMemWb     = 4'd4,
    StMemWrite  = 4'd5,
    StExecR     = 4'd6,
    StExecShift = 4'd7,
    StAluWb     = 4'd8,
    StExecI     = 4'd9,
    StIWb       = 4'd10,
    StBranch    = 4'd11,
    StJump      = 4'd12,
    StJr        = 4'd13,
    StJal       = 4'd14,
    StTrap      = 4'd15
  } state_t;

  // Same encoding as the pipelined core's ALU.
  typedef enum logic [2:0] {
    AluAnd = 3'b000,
    AluOr  = 3'b001,
    AluAdd = 3'b010,
    AluSll = 3'b011,
    AluSrl = 3'b100,
    AluSra = 3'b101,
    AluSub = 3'b110,
    AluSlt = 3'b111
  } alu_ctrl_t;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [5:0] FnSll  = 6'b000000;
  localparam logic [5:0] FnSrl  = 6'b000010;
  localparam logic [5:0] FnSra  = 6'b000011;
  localparam logic [5:0] FnSllv = 6'b000100;
  localparam logic [5:0] FnSrlv = 6'b000110;
  localparam logic [5:0] FnSrav = 6'b000111;
  localparam logic [5:0] FnJr   = 6'b001000;
  localparam logic [5:0] FnAdd  = 6'b100000;
  localparam logic [5:0] FnSub  = 6'b100010;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnSlt  = 6'b101010;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;
  localparam logic [1:0] PcSrcRs     = 2'b11;

  localparam logic [1:0] WaRt   = 2'b00;
  localparam logic [1:0] WaRd   = 2'b01;
  localparam logic [1:0] WaLink = 2'b10;

  localparam logic [1:0] WdAluOut = 2'b00;
  localparam logic [1:0] WdMdr    = 2'b01;
  localparam logic [1:0] WdPc     = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAA     = 2'b01;
  localparam logic [1:0] SrcAShamt = 2'b10;

  localparam logic [1:0] SrcBB      = 2'b00;
  localparam logic [1:0] SrcBFour   = 2'b01;
  localparam logic [1:0] SrcBImm    = 2'b10;
  localparam logic [1:0] SrcBImmSh2 = 2'b11;

endpackage

// File: rtl/mc_perf_counters.sv
// Cycle and retired-instruction counters for the multicycle controller.
// Present only when MULTICYCLE_PERF_CNT_EN is defined.
`ifdef MULTICYCLE_PERF_CNT_EN
module mc_perf_counters (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cycle_inc_i,
  input  logic        instr_inc_i,
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] instr_cnt_o
);

  logic [31:0] cycle_q, cycle_d;
  logic [31:0] instr_q, instr_d;

  always_comb begin
    cycle_d = cycle_q;
    instr_d = instr_q;
    if (cycle_inc_i) cycle_d = cycle_q + 32'd1;
    if (instr_inc_i) instr_d = instr_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      instr_q <= instr_d;
    end
  end

  assign cycle_cnt_o = cycle_q;
  assign instr_cnt_o = instr_q;

endmodule
`endif

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle MIPS core (shared memory port, single ALU).
// Define MULTICYCLE_PERF_CNT_EN to add cycle_cnt/instr_cnt performance counters.
module multicycle_controller
  import mips_pkg::*;
#(
  parameter int unsigned JAL_LINK_REG = 31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] operation,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_re,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       reg_we,
  output logic [1:0] sel_reg_write_addr,
  output logic [1:0] sel_reg_write_data,
  output logic [1:0] sel_alu_src_a,
  output logic [1:0] sel_alu_src_b,
  output logic [2:0] alu_control,
  output logic [3:0] state,
  output logic       illegal
`ifdef MULTICYCLE_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  // The link register index lives in the datapath; only range-check it here.
  if (JAL_LINK_REG > 31) begin : gen_link_reg_check
    $error("JAL_LINK_REG out of range");
  end

  state_t    state_q, state_d;
  logic      illegal_q;
  alu_ctrl_t alu_ctrl;

  always_comb begin
    state_d            = state_q;
    mem_re             = 1'b0;
    mem_we             = 1'b0;
    iord               = 1'b0;
    ir_we              = 1'b0;
    pc_en              = 1'b0;
    pc_src             = PcSrcAlu;
    reg_we             = 1'b0;
    sel_reg_write_addr = WaRt;
    sel_reg_write_data = WdAluOut;
    sel_alu_src_a      = SrcAPc;
    sel_alu_src_b      = SrcBB;
    alu_ctrl           = AluAnd;

    unique case (state_q)
      StFetch: begin
        mem_re        = 1'b1;
        sel_alu_src_b = SrcBFour;
        alu_ctrl      = AluAdd;
        ir_we         = mem_ready;
        pc_en         = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        // Branch target is computed speculatively and parked in ALUOut.
        sel_alu_src_b = SrcBImmSh2;
        alu_ctrl      = AluAdd;
        case (operation)
          OpLw, OpSw:           state_d = StMemAddr;
          OpAddi, OpAndi, OpOri: state_d = StExecI;
          OpBeq, OpBne:         state_d = StBranch;
          OpJ:                  state_d = StJump;
          OpJal:                state_d = StJal;
          OpRtype: begin
            case (func)
              FnSll, FnSrl, FnSra:                  state_d = StExecShift;
              FnJr:                                 state_d = StJr;
              FnAnd, FnOr, FnAdd, FnSub, FnSlt,
              FnSllv, FnSrlv, FnSrav:               state_d = StExecR;
              default:                              state_d = StTrap;
            endcase
          end
          default: state_d = StTrap;
        endcase
      end
      StMemAddr: begin
        sel_alu_src_a = SrcAA;
        sel_alu_src_b = SrcBImm;
        alu_ctrl      = AluAdd;
        state_d       = (operation == OpLw) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        mem_re = 1'b1;
        iord   = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        reg_we             = 1'b1;
        sel_reg_write_data = WdMdr;
        state_d            = StFetch;
      end
      StMemWrite: begin
        mem_we = 1'b1;
        iord   = 1'b1;
        if (mem_ready) state_d = StFetch;
      end
      StExecR: begin
        sel_alu_src_a = SrcAA;
        case (func)
          FnAnd:   alu_ctrl = AluAnd;
          FnOr:    alu_ctrl = AluOr;
          FnSub:   alu_ctrl = AluSub;
          FnSlt:   alu_ctrl = AluSlt;
          FnSllv:  alu_ctrl = AluSll;
          FnSrlv:  alu_ctrl = AluSrl;
          FnSrav:  alu_ctrl = AluSra;
          default: alu_ctrl = AluAdd;
        endcase
        state_d = StAluWb;
      end
      StExecShift: begin
        sel_alu_src_a = SrcAShamt;
        case (func)
          FnSll:   alu_ctrl = AluSll;
          FnSrl:   alu_ctrl = AluSrl;
          default: alu_ctrl = AluSra;
        endcase
        state_d = StAluWb;
      end
      StAluWb: begin
        reg_we             = 1'b1;
        sel_reg_write_addr = WaRd;
        state_d            = StFetch;
      end
      StExecI: begin
        sel_alu_src_a = SrcAA;
        sel_alu_src_b = SrcBImm;
        case (operation)
          OpAndi:  alu_ctrl = AluAnd;
          OpOri:   alu_ctrl = AluOr;
          default: alu_ctrl = AluAdd;
        endcase
        state_d = StIWb;
      end
      StIWb: begin
        reg_we  = 1'b1;
        state_d = StFetch;
      end
      StBranch: begin
        sel_alu_src_a = SrcAA;
        alu_ctrl      = AluSub;
        pc_src        = PcSrcAluOut;
        pc_en         = (operation == OpBne) ? !zero : zero;
        state_d       = StFetch;
      end
      StJump: begin
        pc_src  = PcSrcJump;
        pc_en   = 1'b1;
        state_d = StFetch;
      end
      StJr: begin
        pc_src  = PcSrcRs;
        pc_en   = 1'b1;
        state_d = StFetch;
      end
      StJal: begin
        // PC already holds PC+4 from fetch, so it is the link value.
        pc_src             = PcSrcJump;
        pc_en              = 1'b1;
        reg_we             = 1'b1;
        sel_reg_write_addr = WaLink;
        sel_reg_write_data = WdPc;
        state_d            = StFetch;
      end
      StTrap: state_d = StTrap;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == StTrap) illegal_q <= 1'b1;
    end
  end

  assign alu_control = alu_ctrl;
  assign state       = state_q;
  assign illegal     = illegal_q;

`ifdef MULTICYCLE_PERF_CNT_EN
  mc_perf_counters u_perf_counters (
    .clk         (clk),
    .rst_n       (rst_n),
    .cycle_inc_i (state_q != StTrap),
    .instr_inc_i ((state_q == StFetch) && mem_ready),
    .cycle_cnt_o (cycle_cnt),
    .instr_cnt_o (instr_cnt)
  );
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle vector table run through
// a scoreboard queue, plus latency and reset-abort sequences.
module tb_multicycle_controller;

  localparam logic [5:0] OpR = 6'b000000, OpJ = 6'b000010, OpJal = 6'b000011;
  localparam logic [5:0] OpBeq = 6'b000100, OpBne = 6'b000101, OpAndi = 6'b001100;
  localparam logic [5:0] OpOri = 6'b001101, OpLw = 6'b100011, OpSw = 6'b101011;
  localparam logic [5:0] OpBad = 6'b111111;

  localparam logic [3:0] SF = 4'd0, SD = 4'd1, SMA = 4'd2, SMR = 4'd3, SMWB = 4'd4;
  localparam logic [3:0] SMW = 4'd5, SER = 4'd6, SES = 4'd7, SAWB = 4'd8, SEI = 4'd9;
  localparam logic [3:0] SIWB = 4'd10, SBR = 4'd11, SJ = 4'd12, SJR = 4'd13, SJAL = 4'd14;
  localparam logic [3:0] STRAP = 4'd15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] operation, func;
  logic       zero, mem_ready;
  logic       mem_re, mem_we, iord, ir_we, pc_en, reg_we, illegal;
  logic [1:0] pc_src, sel_reg_write_addr, sel_reg_write_data, sel_alu_src_a, sel_alu_src_b;
  logic [2:0] alu_control;
  logic [3:0] state;
`ifdef MULTICYCLE_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  multicycle_controller #(.JAL_LINK_REG(31)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .operation          (operation),
    .func               (func),
    .zero               (zero),
    .mem_ready          (mem_ready),
    .mem_re             (mem_re),
    .mem_we             (mem_we),
    .iord               (iord),
    .ir_we              (ir_we),
    .pc_en              (pc_en),
    .pc_src             (pc_src),
    .reg_we             (reg_we),
    .sel_reg_write_addr (sel_reg_write_addr),
    .sel_reg_write_data (sel_reg_write_data),
    .sel_alu_src_a      (sel_alu_src_a),
    .sel_alu_src_b      (sel_alu_src_b),
    .alu_control        (alu_control),
    .state              (state),
    .illegal            (illegal)
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    .cycle_cnt          (cycle_cnt),
    .instr_cnt          (instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        rdy;
    logic        rst;
    logic [3:0]  st;
    logic [19:0] outs;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];
  int   passed = 0;
  int   total = 0;

  // {mem_re, mem_we, iord, ir_we, pc_en, pc_src, reg_we, wa, wd, src_a, src_b, alu, illegal}
  function automatic logic [19:0] o(input logic re, we, io, irwe, pcen, input logic [1:0] ps,
                                    input logic rw, input logic [1:0] wa, wd, sa, sb,
                                    input logic [2:0] alu, input logic ill);
    return {re, we, io, irwe, pcen, ps, rw, wa, wd, sa, sb, alu, ill};
  endfunction

  function automatic logic [19:0] e_fetch(input logic r);
    return o(1, 0, 0, r, r, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b010, 0);
  endfunction
  function automatic logic [19:0] e_dec();
    return o(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b11, 3'b010, 0);
  endfunction
  function automatic logic [19:0] e_exr(input logic [2:0] alu);
    return o(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b01, 2'b00, alu, 0);
  endfunction
  function automatic logic [19:0] e_exs(input logic [2:0] alu);
    return o(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b10, 2'b00, alu, 0);
  endfunction
  function automatic logic [19:0] e_exi(input logic [2:0] alu);
    return o(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b01, 2'b10, alu, 0);
  endfunction
  function automatic logic [19:0] e_wb(input logic [1:0] wa, wd);
    return o(0, 0, 0, 0, 0, 2'b00, 1, wa, wd, 2'b00, 2'b00, 3'b000, 0);
  endfunction
  function automatic logic [19:0] e_br(input logic pcen);
    return o(0, 0, 0, 0, pcen, 2'b01, 0, 2'b00, 2'b00, 2'b01, 2'b00, 3'b110, 0);
  endfunction

  task automatic add(input string tag, input logic [5:0] op, fn, input logic z, rdy, rst,
                     input logic [3:0] st, input logic [19:0] outs);
    vec_t v;
    v.tag = tag; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.rst = rst;
    v.st = st; v.outs = outs;
    vecs.push_back(v);
  endtask

  // Fetch (mem_ready=1) then decode; decode drops mem_ready to show it is ignored there.
  task automatic add_fd(input string tag, input logic [5:0] op, fn);
    add({tag, "_fetch"}, op, fn, 0, 1, 1, SF, e_fetch(1));
    add({tag, "_decode"}, op, fn, 0, 0, 1, SD, e_dec());
  endtask

  task automatic check(input string tag, input logic [31:0] got, want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got 'h%0h, want 'h%0h", tag, got, want);
  endtask

  // Drive one cycle, queue its expectation, compare on the falling edge.
  task automatic run_vec(input vec_t v);
    vec_t e;
    operation = v.op; func = v.fn; zero = v.z; mem_ready = v.rdy; rst_n = v.rst;
    sb_q.push_back(v);
    @(negedge clk);
    e = sb_q.pop_front();
    check({e.tag, " state"}, {28'd0, state}, {28'd0, e.st});
    check({e.tag, " outs"},
          {12'd0, mem_re, mem_we, iord, ir_we, pc_en, pc_src, reg_we, sel_reg_write_addr,
           sel_reg_write_data, sel_alu_src_a, sel_alu_src_b, alu_control, illegal},
          {12'd0, e.outs});
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH with mem_ready=1; returns cycles until FETCH again.
  task automatic latency(input string tag, input logic [5:0] op, fn, input int want);
    int n;
    n = 0;
    operation = op; func = fn; zero = 1'b0; mem_ready = 1'b1; rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (state == SF) break;
    end
    check({tag, " latency"}, n, want);
  endtask

  initial begin
    vec_t rv;
`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0] c0, i0;
`endif
    // add $3,$1,$2
    add_fd("add", OpR, 6'b100000);
    add("add_exec", OpR, 6'b100000, 0, 0, 1, SER, e_exr(3'b010));
    add("add_wb", OpR, 6'b100000, 0, 1, 1, SAWB, e_wb(2'b01, 2'b00));
    // lw with two wait states
    add_fd("lw", OpLw, 6'd0);
    add("lw_addr", OpLw, 6'd0, 0, 0, 1, SMA, e_exi(3'b010));
    add("lw_rd0", OpLw, 6'd0, 0, 0, 1, SMR, o(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add("lw_rd1", OpLw, 6'd0, 0, 0, 1, SMR, o(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add("lw_rd2", OpLw, 6'd0, 0, 1, 1, SMR, o(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add("lw_wb", OpLw, 6'd0, 0, 0, 1, SMWB, e_wb(2'b00, 2'b01));
    // sw after a fetch stall
    add("sw_stall", OpSw, 6'd0, 0, 0, 1, SF, e_fetch(0));
    add_fd("sw", OpSw, 6'd0);
    add("sw_addr", OpSw, 6'd0, 0, 1, 1, SMA, e_exi(3'b010));
    add("sw_wr", OpSw, 6'd0, 0, 1, 1, SMW, o(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // branches
    add_fd("beq_t", OpBeq, 6'd0);
    add("beq_t_br", OpBeq, 6'd0, 1, 0, 1, SBR, e_br(1));
    add_fd("bne_nt", OpBne, 6'd0);
    add("bne_nt_br", OpBne, 6'd0, 1, 0, 1, SBR, e_br(0));
    add_fd("bne_t", OpBne, 6'd0);
    add("bne_t_br", OpBne, 6'd0, 0, 1, 1, SBR, e_br(1));
    add_fd("beq_nt", OpBeq, 6'd0);
    add("beq_nt_br", OpBeq, 6'd0, 0, 1, 1, SBR, e_br(0));
    // shifts and other R-type ALU ops
    add_fd("sll", OpR, 6'b000000);
    add("sll_exec", OpR, 6'b000000, 0, 0, 1, SES, e_exs(3'b011));
    add("sll_wb", OpR, 6'b000000, 0, 0, 1, SAWB, e_wb(2'b01, 2'b00));
    add_fd("sra", OpR, 6'b000011);
    add("sra_exec", OpR, 6'b000011, 0, 0, 1, SES, e_exs(3'b101));
    add("sra_wb", OpR, 6'b000011, 0, 0, 1, SAWB, e_wb(2'b01, 2'b00));
    add_fd("sub", OpR, 6'b100010);
    add("sub_exec", OpR, 6'b100010, 0, 0, 1, SER, e_exr(3'b110));
    add("sub_wb", OpR, 6'b100010, 0, 0, 1, SAWB, e_wb(2'b01, 2'b00));
    add_fd("slt", OpR, 6'b101010);
    add("slt_exec", OpR, 6'b101010, 0, 0, 1, SER, e_exr(3'b111));
    add("slt_wb", OpR, 6'b101010, 0, 0, 1, SAWB, e_wb(2'b01, 2'b00));
    add_fd("srlv", OpR, 6'b000110);
    add("srlv_exec", OpR, 6'b000110, 0, 0, 1, SER, e_exr(3'b100));
    add("srlv_wb", OpR, 6'b000110, 0, 0, 1, SAWB, e_wb(2'b01, 2'b00));
    // immediates
    add_fd("ori", OpOri, 6'd0);
    add("ori_exec", OpOri, 6'd0, 0, 0, 1, SEI, e_exi(3'b001));
    add("ori_wb", OpOri, 6'd0, 0, 0, 1, SIWB, e_wb(2'b00, 2'b00));
    add_fd("andi", OpAndi, 6'd0);
    add("andi_exec", OpAndi, 6'd0, 0, 0, 1, SEI, e_exi(3'b000));
    add("andi_wb", OpAndi, 6'd0, 0, 0, 1, SIWB, e_wb(2'b00, 2'b00));
    // jumps
    add_fd("j", OpJ, 6'd0);
    add("j_exec", OpJ, 6'd0, 0, 0, 1, SJ, o(0, 0, 0, 0, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0));
    add_fd("jr", OpR, 6'b001000);
    add("jr_exec", OpR, 6'b001000, 0, 0, 1, SJR, o(0, 0, 0, 0, 1, 2'b11, 0, 0, 0, 0, 0, 0, 0));
    add_fd("jal", OpJal, 6'd0);
    add("jal_exec", OpJal, 6'd0, 0, 0, 1, SJAL,
        o(0, 0, 0, 0, 1, 2'b10, 1, 2'b10, 2'b10, 0, 0, 0, 0));
    // unknown R-type func traps, then reset
    add_fd("badfn", OpR, 6'b111111);
    add("badfn_trap", OpR, 6'b111111, 0, 1, 0, STRAP, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    add("badfn_rst", OpR, 6'b111111, 0, 0, 1, SF, e_fetch(0));
    // illegal opcode: sticky trap for 10 cycles, then reset
    add_fd("badop", OpBad, 6'd0);
    for (int i = 0; i < 10; i++)
      add("badop_trap", OpBad, 6'd0, i[0], 1, 1, STRAP,
          o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    add("badop_rstcyc", OpBad, 6'd0, 0, 1, 0, STRAP, o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    add("badop_after", OpBad, 6'd0, 0, 0, 1, SF, e_fetch(0));

    rst_n = 1'b0; operation = '0; func = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
`ifdef MULTICYCLE_PERF_CNT_EN
    check("perf_reset_instr", instr_cnt, 32'd0);
    check("perf_reset_cycle", cycle_cnt, 32'd0);
`endif

    foreach (vecs[i]) run_vec(vecs[i]);

    // Latency from FETCH with mem_ready held high.
`ifdef MULTICYCLE_PERF_CNT_EN
    c0 = cycle_cnt;
    i0 = instr_cnt;
`endif
    latency("lat_add", OpR, 6'b100000, 4);
    latency("lat_ori", OpOri, 6'd0, 4);
    latency("lat_lw", OpLw, 6'd0, 5);
    latency("lat_sw", OpSw, 6'd0, 4);
    latency("lat_beq", OpBeq, 6'd0, 3);
    latency("lat_j", OpJ, 6'd0, 3);
    latency("lat_jr", OpR, 6'b001000, 3);
    latency("lat_jal", OpJal, 6'd0, 3);
`ifdef MULTICYCLE_PERF_CNT_EN
    check("perf_cycles", cycle_cnt - c0, 32'd29);
    check("perf_instrs", instr_cnt - i0, 32'd8);
`endif

    // Reset while a store is waiting on memory aborts the access.
    mem_ready = 1'b0;
    rv.tag = "swabort_fetch"; rv.op = OpSw; rv.fn = '0; rv.z = 0; rv.rdy = 1; rv.rst = 1;
    rv.st = SF; rv.outs = e_fetch(1);
    run_vec(rv);
    rv.tag = "swabort_dec"; rv.rdy = 0; rv.st = SD; rv.outs = e_dec();
    run_vec(rv);
    rv.tag = "swabort_addr"; rv.st = SMA; rv.outs = e_exi(3'b010);
    run_vec(rv);
    rv.tag = "swabort_wait"; rv.st = SMW; rv.outs = o(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_vec(rv);
    rv.tag = "swabort_rstcyc"; rv.rst = 0;
    run_vec(rv);
    rv.tag = "swabort_after"; rv.rst = 1; rv.st = SF; rv.outs = e_fetch(0);
    run_vec(rv);
`ifdef MULTICYCLE_PERF_CNT_EN
    check("perf_abort_instr", instr_cnt, 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
